// File: rtl/vga_timing_gen_if.sv
// Pixel-domain bus between the VGA timing generator and its pixel source / display sink.
interface vga_timing_gen_if #(
  parameter int unsigned CW = 11
);
  logic          pix_en;
  logic [23:0]   color_in;
  logic          active;
  logic [CW-1:0] active_x;
  logic [CW-1:0] active_y;
  logic          line_start;
  logic          frame_start;
  logic          screenend;
  logic          hsync;
  logic          vsync;
  logic [7:0]    red;
  logic [7:0]    green;
  logic [7:0]    blue;

  modport master (
    input  pix_en, color_in,
    output active, active_x, active_y, line_start, frame_start, screenend,
           hsync, vsync, red, green, blue
  );

  modport slave (
    output pix_en, color_in,
    input  active, active_x, active_y, line_start, frame_start, screenend,
           hsync, vsync, red, green, blue
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, pixel requests, sync/blank
// delay line matched to the pixel-source latency, and registered RGB/sync outputs.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 1024,
  parameter int unsigned H_FRONT   = 24,
  parameter int unsigned H_SYNC    = 136,
  parameter int unsigned H_BACK    = 160,
  parameter int unsigned V_VISIBLE = 768,
  parameter int unsigned V_FRONT   = 3,
  parameter int unsigned V_SYNC    = 6,
  parameter int unsigned V_BACK    = 29,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int unsigned CW        = 11,
  parameter int unsigned PIPE      = 2
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master bus
);

  localparam int unsigned H_LINE  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_FRAME = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SS    = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SE    = H_SS + H_SYNC;
  localparam int unsigned V_SS    = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SE    = V_SS + V_SYNC;
  localparam int unsigned DLW     = 3;

  // After reset the first tick only announces the frame, so frame_start always
  // leads the request for pixel (0,0) by one tick.
  typedef enum logic {ST_PRIME = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             adv_c, prime_c;
  logic [CW-1:0]    h_cnt, v_cnt;
  logic             h_last_c, v_last_c, vis_c, hs_raw_c, vs_raw_c;
  logic             active_q;
  logic [CW-1:0]    ax_q, ay_q;
  logic             line_start_q, frame_start_q, screenend_q;
  logic             hsync_q, vsync_q, vs_s1_q, vs_on_c;
  logic [23:0]      rgb_q;
  logic [DLW-1:0]   dl_in_c, dl_out_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_PRIME;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    adv_c   = 1'b0;
    prime_c = 1'b0;
    case (state_q)
      ST_PRIME: begin
        if (bus.pix_en) begin
          state_d = ST_RUN;
          prime_c = 1'b1;
        end
      end
      ST_RUN:  adv_c = bus.pix_en;
      default: state_d = ST_PRIME;
    endcase
  end

  assign h_last_c = (h_cnt == CW'(H_LINE - 1));
  assign v_last_c = (v_cnt == CW'(V_FRAME - 1));
  assign vis_c    = (h_cnt < CW'(H_VISIBLE)) && (v_cnt < CW'(V_VISIBLE));
  assign hs_raw_c = (h_cnt >= CW'(H_SS)) && (h_cnt < CW'(H_SE));
  assign vs_raw_c = (v_cnt >= CW'(V_SS)) && (v_cnt < CW'(V_SE));

  // Raster position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (adv_c) begin
      h_cnt <= h_last_c ? '0 : h_cnt + CW'(1);
      if (h_last_c) v_cnt <= v_last_c ? '0 : v_cnt + CW'(1);
    end
  end

  // Pixel request; coordinate holds through blanking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      ax_q     <= '0;
      ay_q     <= '0;
    end else if (adv_c) begin
      active_q <= vis_c;
      if (vis_c) begin
        ax_q <= h_cnt;
        ay_q <= v_cnt;
      end
    end
  end

  // Blanking rides on the registered request so it lines up with the returned color
  assign dl_in_c = {hs_raw_c, vs_raw_c, active_q};

  if (PIPE == 0) begin : g_nopipe
    assign dl_out_c = dl_in_c;
  end else begin : g_pipe
    localparam int unsigned SRW = DLW * PIPE;
    logic [SRW-1:0] sr_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)             sr_q <= '0;
      else if (bus.pix_en) sr_q <= (sr_q << DLW) | SRW'(dl_in_c);
    end
    assign dl_out_c = sr_q[SRW-1 -: DLW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      rgb_q   <= '0;
    end else if (bus.pix_en) begin
      hsync_q <= dl_out_c[2] ? HS_POL : ~HS_POL;
      vsync_q <= dl_out_c[1] ? VS_POL : ~VS_POL;
      rgb_q   <= dl_out_c[0] ? bus.color_in : 24'h000000;
    end
  end

  assign vs_on_c = (vsync_q == VS_POL);

  // Single-clock pulses; the vsync edge detector runs every clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      vs_s1_q       <= 1'b0;
      screenend_q   <= 1'b0;
    end else begin
      line_start_q  <= prime_c | (adv_c & h_last_c);
      frame_start_q <= prime_c | (adv_c & h_last_c & v_last_c);
      vs_s1_q       <= vs_on_c;
      screenend_q   <= vs_on_c & ~vs_s1_q;
    end
  end

  assign bus.active      = active_q;
  assign bus.active_x    = ax_q;
  assign bus.active_y    = ay_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.screenend   = screenend_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.red         = rgb_q[23:16];
  assign bus.green       = rgb_q[15:8];
  assign bus.blue        = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a 16x8 raster (H 8/2/3/3, V 4/1/2/1, PIPE=2),
// with a second instance using active-high sync polarity.
module tb_vga_timing_gen;
  localparam int unsigned CW   = 11;
  localparam int unsigned PIPE = 2;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic done = 1'b0;

  vga_timing_gen_if #(.CW(CW)) vif ();
  vga_timing_gen_if #(.CW(CW)) vifp ();

  assign vifp.pix_en   = vif.pix_en;
  assign vifp.color_in = vif.color_in;

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW), .PIPE(PIPE)
  ) u_dut (.clk(clk), .rst(rst), .bus(vif));

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW), .PIPE(PIPE)
  ) u_pol (.clk(clk), .rst(rst), .bus(vifp));

  always #5 clk = ~clk;

  typedef struct packed {
    logic          act;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          hs;
    logic          vs;
    logic [23:0]   rgb;
    logic          ls;
    logic          fs;
    logic          se;
  } rec_t;

  rec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic          hist_act [0:511];
  logic [CW-1:0] hist_x   [0:511];
  logic [CW-1:0] hist_y   [0:511];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] color_of(input bit mode, input logic [CW-1:0] x,
                                           input logic [CW-1:0] y);
    return mode ? 24'hA55AFF : {8'(x), 8'(y), 8'hC3};
  endfunction

  // Drives ticks every `period` clocks, acts as a PIPE-tick pixel source and
  // pushes the hand-derived expected outputs of every tick (tick 0 = priming tick).
  task automatic run(input int n_ticks, input int period, input bit mode);
    int            m, c, p, q;
    logic [23:0]   src1, src2;
    logic          s_act, vs_prev;
    logic [CW-1:0] s_x, s_y, lx, ly;
    rec_t          r;
    bit            en;
    m = 0; c = 0; src1 = 24'h123456; src2 = 24'h123456;
    lx = '0; ly = '0; vs_prev = 1'b0;
    vif.color_in = src2;
    while (m < n_ticks) begin
      en = ((c % period) == (period - 1));
      if (en) begin
        p = m - 1;
        q = m - 3;
        r = '0;
        if (m >= 1) begin
          r.act = ((p % 16) < 8) && (((p / 16) % 8) < 4);
          if (r.act) begin
            lx = CW'(p % 16);
            ly = CW'((p / 16) % 8);
          end
          r.ls = ((p % 16) == 15);
          r.fs = ((p % 16) == 15) && (((p / 16) % 8) == 7);
        end else begin
          r.ls = 1'b1;
          r.fs = 1'b1;
        end
        r.x = lx;
        r.y = ly;
        if (q >= 0) begin
          r.hs = ((q % 16) >= 10) && ((q % 16) <= 12);
          r.vs = (((q / 16) % 8) >= 5) && (((q / 16) % 8) <= 6);
        end
        if (m >= 3 && hist_act[m-3]) r.rgb = color_of(mode, hist_x[m-3], hist_y[m-3]);
        r.se = r.vs && !vs_prev;
        vs_prev = r.vs;
        hist_act[m] = r.act;
        hist_x[m]   = lx;
        hist_y[m]   = ly;
        exp_q.push_back(r);
      end
      vif.pix_en = en;
      @(negedge clk);
      s_act = vif.active; s_x = vif.active_x; s_y = vif.active_y;
      @(posedge clk);
      #1;
      if (en) begin
        src2 = src1;
        src1 = s_act ? color_of(mode, s_x, s_y) : 24'h123456;
        m++;
      end
      vif.color_in = src2;
      c++;
    end
    vif.pix_en = 1'b0;
  endtask

  // Stimulus: reset, two free-running frames, reset at (h=5,v=2), then 1-of-3 ticks
  initial begin
    vif.pix_en   = 1'b0;
    vif.color_in = 24'h0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run(294, 1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run(141, 3, 1'b1);
    repeat (6) @(negedge clk);
    #1 done = 1'b1;
  end

  // Monitor: pops one expectation per tick, checks freeze and pulse width between ticks
  initial begin
    rec_t r, last;
    logic en_prev, se_next, in_reset;
    en_prev = 1'b0; se_next = 1'b0; in_reset = 1'b0; last = '0;
    forever begin
      @(negedge clk or posedge rst or posedge done);
      if (done) begin
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
      if (rst) begin
        if (!in_reset) begin
          in_reset = 1'b1;
          #1;
          chk("rst_active", 32'(vif.active), 32'd0);
          chk("rst_x", 32'(vif.active_x), 32'd0);
          chk("rst_y", 32'(vif.active_y), 32'd0);
          chk("rst_rgb", 32'({vif.red, vif.green, vif.blue}), 32'd0);
          chk("rst_pulses", 32'({vif.line_start, vif.frame_start, vif.screenend}), 32'd0);
          chk("rst_hsync", 32'(vif.hsync), 32'd1);
          chk("rst_vsync", 32'(vif.vsync), 32'd1);
          chk("rst_pol_hsync", 32'(vifp.hsync), 32'd0);
          chk("rst_pol_vsync", 32'(vifp.vsync), 32'd0);
        end
        en_prev = 1'b0; se_next = 1'b0; last = '0;
        continue;
      end
      in_reset = 1'b0;
      chk("screenend", 32'(vif.screenend), 32'(se_next));
      if (en_prev) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL underflow: tick seen with no expectation at %0t", $time);
          se_next = 1'b0;
        end else begin
          r = exp_q.pop_front();
          chk("active", 32'(vif.active), 32'(r.act));
          chk("active_x", 32'(vif.active_x), 32'(r.x));
          chk("active_y", 32'(vif.active_y), 32'(r.y));
          chk("hsync", 32'(vif.hsync), 32'(!r.hs));
          chk("vsync", 32'(vif.vsync), 32'(!r.vs));
          chk("rgb", 32'({vif.red, vif.green, vif.blue}), 32'(r.rgb));
          chk("line_start", 32'(vif.line_start), 32'(r.ls));
          chk("frame_start", 32'(vif.frame_start), 32'(r.fs));
          chk("pol_hsync", 32'(vifp.hsync), 32'(r.hs));
          chk("pol_vsync", 32'(vifp.vsync), 32'(r.vs));
          last = r;
          se_next = r.se;
        end
      end else begin
        chk("idle_pulses", 32'({vif.line_start, vif.frame_start}), 32'd0);
        chk("hold_active", 32'(vif.active), 32'(last.act));
        chk("hold_xy", 32'({vif.active_x, vif.active_y}), 32'({last.x, last.y}));
        chk("hold_sync", 32'({vif.hsync, vif.vsync}), 32'({!last.hs, !last.vs}));
        chk("hold_rgb", 32'({vif.red, vif.green, vif.blue}), 32'(last.rgb));
        se_next = 1'b0;
      end
      en_prev = vif.pix_en;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL provide parameter H_VISIBLE, default 1024, visible pixels per line.
REQ-002 SHALL provide parameters H_FRONT/H_SYNC/H_BACK, defaults 24/136/160, horizontal porch and sync widths in pixels.
REQ-003 SHALL provide parameter V_VISIBLE, default 768, visible lines per frame.
REQ-004 SHALL provide parameters V_FRONT/V_SYNC/V_BACK, defaults 3/6/29, vertical porch and sync widths in lines.
REQ-005 SHALL provide parameters HS_POL/VS_POL, default 0/0, asserted sync level (0 = active-low).
REQ-006 SHALL provide parameter CW, default 11, width of coordinate outputs and internal counters.
REQ-007 SHALL provide parameter PIPE, default 2, range 0..7, pixel-source latency in pix_en ticks.
REQ-008 SHALL have port clk, input, 1, single pixel-domain clock; all logic on posedge clk only.
REQ-009 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-010 SHALL have port pix_en, input, 1, pixel tick; all state advances only in cycles with pix_en=1.
REQ-011 SHALL have port color_in, input, 24, {R,G,B} for coordinate requested PIPE ticks earlier.
REQ-012 SHALL have ports active, active_x[CW], active_y[CW], outputs, pixel request valid and coordinate.
REQ-013 SHALL have ports line_start, frame_start, screenend, outputs, 1, single-cycle pulses.
REQ-014 SHALL have ports hsync, vsync, output, 1, and red/green/blue, output, 8 each.

Function
REQ-015 h_cnt SHALL count 0..H_LINE-1 (H_LINE = sum of H params) per pix_en tick, then wrap to 0.
REQ-016 v_cnt SHALL count 0..V_FRAME-1, incrementing only on the pix_en tick where h_cnt wraps; wraps to 0 after V_FRAME-1.
REQ-017 Line order SHALL be visible, front porch, sync, back porch; likewise for frame.
REQ-018 active SHALL be registered: 1 one pix_en tick after h_cnt<H_VISIBLE and v_cnt<V_VISIBLE, with active_x=h_cnt, active_y=v_cnt of that tick.
REQ-019 active_x/active_y SHALL hold last value while active=0 and while pix_en=0.
REQ-020 line_start SHALL pulse one clk cycle on the pix_en tick where h_cnt becomes 0; frame_start SHALL pulse when both counters become 0.
REQ-021 Raw hsync SHALL be asserted while H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC; raw vsync analogous on v_cnt.
REQ-022 hsync, vsync and blanking SHALL pass through a PIPE-stage pix_en-gated delay line plus one output register, aligning with color_in.
REQ-023 red/green/blue SHALL register color_in when delayed active=1 and pix_en=1, else 0.
REQ-024 hsync/vsync output level SHALL be XOR-mapped per HS_POL/VS_POL; deasserted level = ~POL.
REQ-025 screenend SHALL pulse one clk cycle when output vsync transitions deasserted->asserted, via a 2-stage edge detector.
REQ-026 With pix_en held 1 permanently, timing SHALL match a free-running 1-pixel-per-clk generator.
REQ-027 pix_en=0 SHALL freeze all counters, delay lines and outputs except pulses, which SHALL drop to 0.

Reset
REQ-028 rst=1 SHALL asynchronously clear h_cnt, v_cnt, delay lines, active, active_x, active_y, pulses and RGB to 0.
REQ-029 During reset hsync/vsync SHALL drive deasserted level ~HS_POL/~VS_POL.
REQ-030 After rst falls, first pix_en tick SHALL be h_cnt=0, v_cnt=0; reset mid-frame SHALL restart from pixel (0,0) with no stale RGB.

Verification (H 8/2/3/3, H_LINE=16; V 4/1/2/1, V_FRAME=8; PIPE=2; pols 0)
REQ-031 pix_en=1, color_in=counter -> active high 8 of every 16 clks on lines 0..3, active_x 0..7 in order.
REQ-032 Same -> hsync low 3 clks per line starting 13 clks after line_start (1+PIPE+h offset 10), vsync low 2 lines per 128-clk frame, screenend once per frame.
REQ-033 color_in=0xA5_5A_FF during active, else 0x123456 -> RGB = A5/5A/FF exactly in 8-pixel window aligned to hsync, zero elsewhere.
REQ-034 pix_en toggled 1-of-3 clks -> all periods triple; pulses remain 1 clk wide.
REQ-035 rst asserted mid-line at h_cnt=5, v_cnt=2 -> outputs reset same cycle without clk edge; after release, frame_start precedes active_x=0,y=0.
REQ-036 HS_POL=VS_POL=1 -> sync waveforms inverted, idle level 0 under reset.
